// File: rtl/serial_lane_pkg.sv
// Shared types and helpers for the serial lane scheduler.
package serial_lane_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } lane_state_t;

   // Index width that never collapses to zero bits for tiny counts.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter
   import serial_lane_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]                 req,
   input  logic [clog2_min1(NREQ)-1:0]     ptr,
   input  logic                            en,
   output logic [NREQ-1:0]                 grant,
   output logic [clog2_min1(NREQ)-1:0]     grant_idx
);

   localparam int IW = clog2_min1(NREQ);

   int   idx;
   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (en && !found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = IW'(idx);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/serial_lane_sched.sv
// Shares one MSB-first serial lane between NREQ word producers, with a fixed idle gap per frame.
module serial_lane_sched
   import serial_lane_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREQ  = 2,
   parameter int GAP   = 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NREQ-1:0]               req_valid,
   input  logic [NREQ*WIDTH-1:0]         req_data,
   output logic [NREQ-1:0]               req_ready,
   input  logic                          abort,
   output logic                          sdo,
   output logic                          sdo_en,
   output logic [clog2_min1(NREQ)-1:0]   grant_id,
   output logic                          busy,
   output logic                          done
);

   localparam int IW = clog2_min1(NREQ);
   localparam int CW = clog2_min1(WIDTH);

   // Handshake: a word moves on a rising edge where req_valid[i] and req_ready[i]
   // are both high; req_ready is one-hot and only offered in IDLE without abort.

   lane_state_t      state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    bit_cnt;
   logic [3:0]       gap_cnt;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    g_idx;
   logic [NREQ-1:0]  grant;
   logic             arb_en;
   logic             accept;
   logic [WIDTH-1:0] word;

   assign arb_en    = reset_n && (state == ST_IDLE) && !abort;
   assign req_ready = grant;
   assign accept    = |(req_valid & grant);
   assign word      = req_data[g_idx*WIDTH +: WIDTH];

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req       (req_valid),
      .ptr       (ptr),
      .en        (arb_en),
      .grant     (grant),
      .grant_idx (g_idx)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
         ptr      <= '0;
         grant_id <= '0;
         sdo      <= 1'b0;
         sdo_en   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  // MSB goes straight to the output register; shreg holds what follows.
                  state    <= ST_SHIFT;
                  shreg    <= word << 1;
                  sdo      <= word[WIDTH-1];
                  sdo_en   <= 1'b1;
                  busy     <= 1'b1;
                  bit_cnt  <= '0;
                  grant_id <= g_idx;
                  ptr      <= (g_idx == IW'(NREQ - 1)) ? '0 : g_idx + 1'b1;
               end
            end
            ST_SHIFT: begin
               if (abort) begin
                  state   <= ST_IDLE;
                  shreg   <= '0;
                  bit_cnt <= '0;
                  sdo     <= 1'b0;
                  sdo_en  <= 1'b0;
                  busy    <= 1'b0;
               end else if (bit_cnt == CW'(WIDTH - 1)) begin
                  done    <= 1'b1;
                  shreg   <= '0;
                  bit_cnt <= '0;
                  sdo     <= 1'b0;
                  sdo_en  <= 1'b0;
                  gap_cnt <= '0;
                  if (GAP > 0) begin
                     state <= ST_GAP;
                     busy  <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  sdo     <= shreg[WIDTH-1];
                  shreg   <= shreg << 1;
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (abort || gap_cnt == 4'(GAP - 1)) begin
                  state   <= ST_IDLE;
                  gap_cnt <= '0;
                  busy    <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_lane_sched.sv
// Bench for serial_lane_sched: vector table, corner sequences and a random run against a frame-level model.
module tb_serial_lane_sched;

   localparam int W = 8;
   localparam int N = 2;
   localparam int G = 1;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [N-1:0]     req_valid = '0;
   logic [N*W-1:0]   req_data = '0;
   logic             abort = 1'b0;

   logic [N-1:0] req_ready, ready_g0, ready_g15;
   logic         sdo, sdo_en, busy, done;
   logic         sdo_g0, sdo_en_g0, busy_g0, done_g0;
   logic         sdo_g15, sdo_en_g15, busy_g15, done_g15;
   logic [0:0]   grant_id, gid_g0, gid_g15;

   always #5 clk = ~clk;

   serial_lane_sched #(.WIDTH(W), .NREQ(N), .GAP(G)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .abort(abort), .sdo(sdo), .sdo_en(sdo_en),
      .grant_id(grant_id), .busy(busy), .done(done));

   serial_lane_sched #(.WIDTH(W), .NREQ(N), .GAP(0)) dut_g0 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(ready_g0), .abort(abort), .sdo(sdo_g0), .sdo_en(sdo_en_g0),
      .grant_id(gid_g0), .busy(busy_g0), .done(done_g0));

   serial_lane_sched #(.WIDTH(W), .NREQ(N), .GAP(15)) dut_g15 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(ready_g15), .abort(abort), .sdo(sdo_g15), .sdo_en(sdo_en_g15),
      .grant_id(gid_g15), .busy(busy_g15), .done(done_g15));

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Frame-level model: remaining cycles of the current frame (shift + gap).
   int          m_left = 0;
   int          m_ptr = 0;
   int          m_gid = 0;
   logic [W-1:0] m_word = '0;
   bit          m_done = 0;

   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      m_left = 0; m_ptr = 0; m_gid = 0; m_done = 0;
   endtask

   task automatic model_check();
      logic [N-1:0] er;
      logic         een, esdo;
      int           pick;
      if (!reset_n) model_reset();
      een  = (m_left > G);
      esdo = 1'b0;
      if (een) esdo = m_word[W - 1 - (W + G - m_left)];
      er = '0;
      if (reset_n && m_left == 0 && !abort) begin
         pick = rr_pick(req_valid, m_ptr);
         if (pick >= 0) er[pick] = 1'b1;
      end
      chk("m_req_ready", int'(req_ready), int'(er));
      chk("m_sdo_en", int'(sdo_en), int'(een));
      chk("m_sdo", int'(sdo), int'(esdo));
      chk("m_busy", int'(busy), int'(m_left > 0));
      chk("m_done", int'(done), int'(m_done));
      chk("m_grant_id", int'(grant_id), m_gid);
   endtask

   task automatic model_edge();
      int pick;
      if (!reset_n) begin
         model_reset();
         return;
      end
      m_done = 0;
      if (m_left > 0) begin
         if (abort) m_left = 0;
         else begin
            if (m_left == G + 1) m_done = 1;
            m_left--;
         end
      end else if (!abort) begin
         pick = rr_pick(req_valid, m_ptr);
         if (pick >= 0) begin
            m_word = req_data[pick*W +: W];
            m_left = W + G;
            m_gid  = pick;
            m_ptr  = (pick + 1) % N;
         end
      end
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic step();
      #1 model_check();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic [N-1:0] valid;
      logic [W-1:0] d0;
      logic         rdy0;
      logic         en;
      logic         sd;
      logic         dn;
      logic         bz;
   } vec_t;

   vec_t        tbl[11];
   logic [W-1:0] a5;
   logic [31:0] bits_acc;
   int          nbits, ndone, hs_n;
   bit          hs;
   int          dm_q[$], d0_q[$], d15_q[$];
   int          hs_idx[$], hs_cyc[$];

   initial begin
      // single-frame vectors for 0xA5 on requester 0
      a5 = 8'hA5;
      tbl[0] = '{2'b01, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 1; i <= 8; i++)
         tbl[i] = '{2'b00, 8'hA5, 1'b0, 1'b1, a5[8 - i], 1'b0, 1'b1};
      tbl[9]  = '{2'b00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[10] = '{2'b00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      @(negedge clk);
      // reset state with both requesters asserting
      req_valid = 2'b11;
      #1;
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_sdo", int'(sdo), 0);
      chk("rst_sdo_en", int'(sdo_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_grant_id", int'(grant_id), 0);
      @(negedge clk);
      req_valid = '0;
      do_reset();

      // single frame
      for (int i = 0; i < 11; i++) begin
         req_valid = tbl[i].valid;
         req_data[W-1:0] = tbl[i].d0;
         #1;
         chk($sformatf("tbl%0d_ready0", i), int'(req_ready[0]), int'(tbl[i].rdy0));
         chk($sformatf("tbl%0d_sdo_en", i), int'(sdo_en), int'(tbl[i].en));
         chk($sformatf("tbl%0d_sdo", i), int'(sdo), int'(tbl[i].sd));
         chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].dn));
         chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].bz));
         step();
      end
      chk("single_grant_id", int'(grant_id), 0);

      // contention: both valid from reset
      req_data = {8'hF0, 8'h0F};
      req_valid = 2'b11;
      do_reset();
      bits_acc = '0; nbits = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (req_ready[0] && req_valid[0]) begin hs_idx.push_back(0); hs_cyc.push_back(c); end
         if (req_ready[1] && req_valid[1]) begin hs_idx.push_back(1); hs_cyc.push_back(c); end
         if (sdo_en) begin bits_acc = {bits_acc[30:0], sdo}; nbits++; end
         step();
      end
      chk("cont_hs_count", hs_idx.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < hs_idx.size()) begin
            chk($sformatf("cont_grant%0d", k), hs_idx[k], k % 2);
            chk($sformatf("cont_start%0d", k), hs_cyc[k], 10 * k);
         end
      end
      chk("cont_nbits", nbits, 32);
      chk("cont_stream", int'(bits_acc), 32'h0FF00FF0);

      // abort mid-frame
      req_valid = '0;
      do_reset();
      req_data = {8'h3C, 8'hFF};
      req_valid = 2'b01;
      step();
      req_valid = '0;
      step(); step(); step(); step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      #1;
      chk("abort_sdo_en", int'(sdo_en), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      req_valid = 2'b10;
      bits_acc = '0; nbits = 0; ndone = 0;
      for (int c = 0; c < 14; c++) begin
         #1;
         hs = req_ready[1] && req_valid[1];
         if (sdo_en) begin bits_acc = {bits_acc[30:0], sdo}; nbits++; end
         if (done) ndone++;
         step();
         if (hs) req_valid = '0;
      end
      chk("post_abort_nbits", nbits, 8);
      chk("post_abort_word", int'(bits_acc[7:0]), 8'h3C);
      chk("post_abort_done", ndone, 1);
      chk("post_abort_gid", int'(grant_id), 1);

      // asynchronous reset mid-shift
      do_reset();
      req_data = {8'h55, 8'hC3};
      req_valid = 2'b01;
      step();
      req_valid = '0;
      step(); step(); step();
      req_valid = 2'b11;
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_sdo", int'(sdo), 0);
      chk("arst_sdo_en", int'(sdo_en), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_ready", int'(req_ready), 0);
      chk("arst_grant_id", int'(grant_id), 0);
      step();
      step();
      reset_n = 1'b1;
      #1;
      chk("arst_ptr_zero", int'(req_ready), 1);
      req_valid = 2'b10;
      step();
      req_valid = '0;
      chk("arst_gid1", int'(grant_id), 1);
      for (int c = 0; c < 10; c++) step();

      // gap variants: periods 10 (GAP=1), 9 (GAP=0), 24 (GAP=15)
      req_data = {8'hF0, 8'h0F};
      req_valid = 2'b11;
      do_reset();
      for (int c = 0; c < 70; c++) begin
         #1;
         if (done) dm_q.push_back(c);
         if (done_g0) begin
            d0_q.push_back(c);
            chk("g0_done_with_handshake", int'(|ready_g0), 1);
         end
         if (done_g15) d15_q.push_back(c);
         step();
      end
      chk("gm_done_first", (dm_q.size() > 0) ? dm_q[0] : -1, 9);
      chk("gm_period", (dm_q.size() > 1) ? dm_q[1] - dm_q[0] : -1, 10);
      chk("g0_period", (d0_q.size() > 1) ? d0_q[1] - d0_q[0] : -1, 9);
      chk("g15_period", (d15_q.size() > 1) ? d15_q[1] - d15_q[0] : -1, 24);

      // data stability: requester data changes while shifting
      req_valid = '0;
      do_reset();
      req_data[W-1:0] = 8'h96;
      req_valid = 2'b01;
      bits_acc = '0; nbits = 0; hs_n = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (req_ready[0] && req_valid[0]) hs_n++;
         if (sdo_en) begin bits_acc = {bits_acc[30:0], sdo}; nbits++; end
         step();
         if (hs_n > 0) begin
            req_valid = '0;
            req_data[W-1:0] = 8'($urandom);
         end
      end
      chk("stable_nbits", nbits, 8);
      chk("stable_word", int'(bits_acc[7:0]), 8'h96);

      // random traffic against the model
      do_reset();
      for (int c = 0; c < 500; c++) begin
         req_valid = N'($urandom_range(0, 3));
         req_data  = (N*W)'($urandom);
         abort     = ($urandom_range(0, 24) == 0);
         step();
      end
      abort = 1'b0;
      req_valid = '0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
